if_id_pipe_reg: RTL

IF/ID pipeline register of the 5-stage MIPS core. It sits between instruction fetch and decode, and directly feeds the control unit's opcode_IF_ID / func_IF_ID inputs and imm16 field. It captures the fetched instruction and PC+4 on ihit, and holds on hazard stall. It squashes to a NOP bubble on flush or fetch miss, and latches HALT so no younger instruction enters decode. A saturating bubble counter supports performance debug.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/pipeline_regs_pkg.sv | 29 ++
 rtl/if_id_if.sv | 30 +++
 rtl/sat_counter.sv | 32 +++
 rtl/if_id_pipe_reg.sv | 97 +++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared ISA types for the 5-stage MIPS core (opcode encodings).
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    // Primary opcode field encodings, instr[31:26]
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/pipeline_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_regs_pkg
//  Description : Payload types and constants for the inter-stage pipeline
//                registers (IF/ID now; ID/EX, EX/MEM, MEM/WB to follow).
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_regs_pkg;

    // sll $0,$0,0 -- architecturally a no-op, used as the bubble instruction
    localparam logic [31:0] c_nop_instr = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
    } if_id_t;

    // Bubble payload: NOP word, zero PC, not valid
    function automatic if_id_t make_bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr = nop;
        b.npc   = 32'h0000_0000;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage : pipeline_regs_pkg
`default_nettype wire

// File: rtl/if_id_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_if
//  Description : Bundle of the IF/ID boundary signals with views for the
//                fetch stage, decode stage and hazard unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_id_if (
    input logic clk
);
    logic        ihit;
    logic        stall;
    logic        flush;
    logic [31:0] instr_IF;
    logic [31:0] npc_IF;
    logic [31:0] instr_ID;
    logic [31:0] npc_ID;
    logic        valid_ID;
    logic        halt_latched;

    // Fetch drives the new instruction; stall also freezes its PC
    modport fetch  (input clk, output ihit, instr_IF, npc_IF,
                    input stall, halt_latched);
    // Decode consumes the registered instruction
    modport decode (input clk, input instr_ID, npc_ID, valid_ID);
    // Hazard unit controls hold/squash and observes what is in decode
    modport hazard (input clk, output stall, flush,
                    input instr_ID, valid_ID, halt_latched);
endinterface : if_id_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Synchronous up-counter that sticks at all-ones instead of
//                wrapping. Used for performance/debug event counts.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count events, holding once every bit is set
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_pipe_reg
//  Description : IF/ID pipeline register. Captures instruction/PC+4 on ihit,
//                holds on stall, squashes to a NOP bubble on flush or fetch
//                miss, and latches HALT so nothing younger reaches decode.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_pipe_reg
    import cpu_types_pkg::*;
    import pipeline_regs_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR   = c_nop_instr,
    parameter logic [5:0]  HALT_OPCODE = OP_HALT,
    parameter int          CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      instr_IF,
    input  logic [31:0]      npc_IF,
    output logic [31:0]      instr_ID,
    output logic [31:0]      npc_ID,
    output logic [5:0]       opcode_IF_ID,
    output logic [5:0]       func_IF_ID,
    output logic [15:0]      imm16_IF_ID,
    output logic [4:0]       rs_ID,
    output logic [4:0]       rt_ID,
    output logic [4:0]       rd_ID,
    output logic [4:0]       shamt_ID,
    output logic             valid_ID,
    output logic             halt_latched,
    output logic [CNT_W-1:0] bubble_cnt
);

    if_id_t r_if_id;
    logic   r_halt;
    logic   w_is_halt;
    logic   w_load_bubble;

    assign w_is_halt = (instr_IF[31:26] == HALT_OPCODE);

    // A bubble is loaded on flush (even over stall), or when not stalled and
    // either HALT is latched or fetch missed. Reset is handled in the counter.
    assign w_load_bubble = flush | (~stall & (r_halt | ~ihit));

    // Pipeline register and halt latch, priority: RST, flush, stall, halt, ihit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_if_id <= make_bubble(NOP_INSTR);
            r_halt  <= 1'b0;
        end else if (flush) begin
            r_if_id <= make_bubble(NOP_INSTR);
            r_halt  <= 1'b0;
        end else if (stall) begin
            r_if_id <= r_if_id;
            r_halt  <= r_halt;
        end else if (r_halt) begin
            r_if_id <= make_bubble(NOP_INSTR);
        end else if (ihit) begin
            r_if_id.instr <= instr_IF;
            r_if_id.npc   <= npc_IF;
            r_if_id.valid <= 1'b1;
            r_halt        <= w_is_halt;
        end else begin
            r_if_id <= make_bubble(NOP_INSTR);
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubble_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clear (1'b0),
        .inc   (w_load_bubble),
        .count (bubble_cnt)
    );

    assign instr_ID     = r_if_id.instr;
    assign npc_ID       = r_if_id.npc;
    assign valid_ID     = r_if_id.valid;
    assign halt_latched = r_halt;

    // Decode-side field slices of the registered instruction
    assign opcode_IF_ID = r_if_id.instr[31:26];
    assign rs_ID        = r_if_id.instr[25:21];
    assign rt_ID        = r_if_id.instr[20:16];
    assign rd_ID        = r_if_id.instr[15:11];
    assign shamt_ID     = r_if_id.instr[10:6];
    assign func_IF_ID   = r_if_id.instr[5:0];
    assign imm16_IF_ID  = r_if_id.instr[15:0];

endmodule : if_id_pipe_reg
`default_nettype wire
